// File: rtl/axi4_types.sv
// Shared AXI4-Lite types: response codes, FSM state enums and PROT bit positions.
// AXI4_LITE_PROT_CHECK_EN makes unprivileged accesses (PROT[0]=0) fail with SLVERR.
package axi4_types;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    localparam int PROT_PRIV  = 0;
    localparam int PROT_NSEC  = 1;
    localparam int PROT_INSTR = 2;

    function automatic logic prot_fault(input logic [2:0] prot);
`ifdef AXI4_LITE_PROT_CHECK_EN
        return (prot & (3'b001 << PROT_PRIV)) == 3'b000;
`else
        return (prot & 3'b000) != 3'b000;
`endif
    endfunction

endpackage

// File: rtl/axi4_lite_wr_ctrl.sv
// Write-side controller: AW/W holding registers, write FSM and B channel.
// Emits a single-cycle commit strobe; PROT checking follows AXI4_LITE_PROT_CHECK_EN.
module axi4_lite_wr_ctrl
    import axi4_types::*;
#(
    parameter int SIZE_WORD = 32,
    parameter int ADDR_W    = 12,
    parameter int N_REGS    = 16,
    localparam int SIZE_STRB = SIZE_WORD / 8,
    localparam int ADDR_LSB  = $clog2(SIZE_STRB),
    localparam int IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                 ACLK,
    input  logic                 ARSTn,
    input  logic                 rst_done,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [ADDR_W-1:0]    AWADDR,
    input  logic [2:0]           AWPROT,
    input  logic                 WVALID,
    output logic                 WREADY,
    input  logic [SIZE_WORD-1:0] WDATA,
    input  logic [SIZE_STRB-1:0] WSTRB,
    output logic                 BVALID,
    input  logic                 BREADY,
    output logic [1:0]           BRESP,
    output logic                 commit_o,
    output logic [IDX_W-1:0]     commit_idx_o,
    output logic [SIZE_WORD-1:0] commit_data_o,
    output logic [SIZE_STRB-1:0] commit_strb_o,
    output logic                 commit_err_o
);

    wr_state_t             state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2:0]            prot_q, prot_d;
    logic [SIZE_WORD-1:0]  data_q, data_d;
    logic [SIZE_STRB-1:0]  strb_q, strb_d;
    resp_t                 bresp_q, bresp_d;

    logic                  aw_hs, w_hs, commit, err;
    logic [ADDR_W-1:0]     cur_addr, word_addr;
    logic [2:0]            cur_prot;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        prot_d  = prot_q;
        data_d  = data_q;
        strb_d  = strb_q;
        bresp_d = bresp_q;
        commit  = 1'b0;

        AWREADY = rst_done & (state_q == W_IDLE || state_q == W_HAVE_W);
        WREADY  = rst_done & (state_q == W_IDLE || state_q == W_HAVE_AW);
        aw_hs   = AWVALID & AWREADY;
        w_hs    = WVALID & WREADY;

        // Whichever half arrived earlier comes from the holding register.
        cur_addr      = (state_q == W_HAVE_AW) ? addr_q : AWADDR;
        cur_prot      = (state_q == W_HAVE_AW) ? prot_q : AWPROT;
        commit_data_o = (state_q == W_HAVE_W)  ? data_q : WDATA;
        commit_strb_o = (state_q == W_HAVE_W)  ? strb_q : WSTRB;
        word_addr     = cur_addr >> ADDR_LSB;
        err = !({1'b0, word_addr} < (ADDR_W + 1)'(N_REGS)) | prot_fault(cur_prot);

        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    addr_d  = AWADDR;
                    prot_d  = AWPROT;
                    state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    data_d  = WDATA;
                    strb_d  = WSTRB;
                    state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: commit = w_hs;
            W_HAVE_W:  commit = aw_hs;
            W_RESP:    if (BREADY) state_d = W_IDLE;
            default:   state_d = W_IDLE;
        endcase

        if (commit) begin
            state_d = W_RESP;
            bresp_d = err ? SLVERR : OKAY;
        end

        commit_o     = commit;
        commit_err_o = err;
        commit_idx_o = word_addr[IDX_W-1:0];
        BVALID       = (state_q == W_RESP);
        BRESP        = bresp_q;
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q <= W_IDLE;
            addr_q  <= '0;
            prot_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            prot_q  <= prot_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            bresp_q <= bresp_d;
        end
    end

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite register-file slave: read FSM, register bank and per-register write pulses.
// Build option AXI4_LITE_PROT_CHECK_EN rejects unprivileged accesses with SLVERR.
module axi4_lite_regfile_slave
    import axi4_types::*;
#(
    parameter int SIZE_WORD = 32,
    parameter int ADDR_W    = 12,
    parameter int N_REGS    = 16,
    localparam int SIZE_STRB = SIZE_WORD / 8,
    localparam int ADDR_LSB  = $clog2(SIZE_STRB),
    localparam int IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                        ACLK,
    input  logic                        ARSTn,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [ADDR_W-1:0]           AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        WVALID,
    output logic                        WREADY,
    input  logic [SIZE_WORD-1:0]        WDATA,
    input  logic [SIZE_STRB-1:0]        WSTRB,
    output logic                        BVALID,
    input  logic                        BREADY,
    output logic [1:0]                  BRESP,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    input  logic [ADDR_W-1:0]           ARADDR,
    input  logic [2:0]                  ARPROT,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [SIZE_WORD-1:0]        RDATA,
    output logic [1:0]                  RRESP,
    output logic [N_REGS*SIZE_WORD-1:0] regs_o,
    output logic [N_REGS-1:0]           wr_pulse_o
);

    logic                              rst_done_q, rst_done_d;
    rd_state_t                         rd_state_q, rd_state_d;
    logic [SIZE_WORD-1:0]              rdata_q, rdata_d;
    resp_t                             rresp_q, rresp_d;
    logic [N_REGS-1:0][SIZE_WORD-1:0]  regs_q, regs_d;
    logic [N_REGS-1:0]                 wr_pulse_q, wr_pulse_d;

    logic                              commit, commit_err;
    logic [IDX_W-1:0]                  commit_idx;
    logic [SIZE_WORD-1:0]              commit_data;
    logic [SIZE_STRB-1:0]              commit_strb;
    logic [ADDR_W-1:0]                 ar_word;
    logic                              ar_err;

    axi4_lite_wr_ctrl #(
        .SIZE_WORD (SIZE_WORD),
        .ADDR_W    (ADDR_W),
        .N_REGS    (N_REGS)
    ) u_wr_ctrl (
        .ACLK          (ACLK),
        .ARSTn         (ARSTn),
        .rst_done      (rst_done_q),
        .AWVALID       (AWVALID),
        .AWREADY       (AWREADY),
        .AWADDR        (AWADDR),
        .AWPROT        (AWPROT),
        .WVALID        (WVALID),
        .WREADY        (WREADY),
        .WDATA         (WDATA),
        .WSTRB         (WSTRB),
        .BVALID        (BVALID),
        .BREADY        (BREADY),
        .BRESP         (BRESP),
        .commit_o      (commit),
        .commit_idx_o  (commit_idx),
        .commit_data_o (commit_data),
        .commit_strb_o (commit_strb),
        .commit_err_o  (commit_err)
    );

    always_comb begin
        rst_done_d = 1'b1;
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;

        ARREADY = rst_done_q & (rd_state_q == R_IDLE);
        ar_word = ARADDR >> ADDR_LSB;
        ar_err  = !({1'b0, ar_word} < (ADDR_W + 1)'(N_REGS)) | prot_fault(ARPROT);

        // Reads sample regs_q, so a same-edge commit is seen only by later reads.
        case (rd_state_q)
            R_IDLE: if (ARVALID && ARREADY) begin
                rdata_d    = ar_err ? '0 : regs_q[ar_word[IDX_W-1:0]];
                rresp_d    = ar_err ? SLVERR : OKAY;
                rd_state_d = R_DATA;
            end
            R_DATA:  if (RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase

        if (commit && !commit_err) begin
            for (int i = 0; i < SIZE_STRB; i++) begin
                if (commit_strb[i]) regs_d[commit_idx][i*8 +: 8] = commit_data[i*8 +: 8];
            end
            wr_pulse_d[commit_idx] = |commit_strb;
        end

        RVALID     = (rd_state_q == R_DATA);
        RDATA      = rdata_q;
        RRESP      = rresp_q;
        regs_o     = regs_q;
        wr_pulse_o = wr_pulse_q;
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            rst_done_q <= 1'b0;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            rst_done_q <= rst_done_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for axi4_lite_regfile_slave: vector table plus multi-cycle sequences.
// Expects SLVERR for unprivileged writes when AXI4_LITE_PROT_CHECK_EN is defined.
module tb_axi4_lite_regfile_slave;

    logic        ACLK = 1'b0;
    logic        ARSTn;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [11:0] AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [511:0] regs_o;
    logic [15:0] wr_pulse_o;

    int n_checks = 0;
    int n_errs   = 0;

    axi4_lite_regfile_slave dut (
        .ACLK(ACLK), .ARSTn(ARSTn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] val;
        logic [15:0] pulse;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input int k);
        return regs_o[k*32 +: 32];
    endfunction

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot,
                             output logic rdy, output logic bv, output logic [1:0] resp,
                             output logic [15:0] pulse, output logic [15:0] pulse_after);
        int n = 0;
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWADDR = addr; AWPROT = prot;
        WVALID  = 1'b1; WDATA  = data; WSTRB  = strb;
        @(negedge ACLK);
        while (!(AWREADY && WREADY) && n < 20) begin @(negedge ACLK); n++; end
        rdy = AWREADY && WREADY;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        bv = BVALID; resp = BRESP; pulse = wr_pulse_o;
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        pulse_after = wr_pulse_o;
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [2:0] prot,
                            output logic rdy, output logic rv, output logic [1:0] resp,
                            output logic [31:0] data);
        int n = 0;
        @(posedge ACLK); #1;
        ARVALID = 1'b1; ARADDR = addr; ARPROT = prot;
        @(negedge ACLK);
        while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
        rdy = ARREADY;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        @(negedge ACLK);
        rv = RVALID; resp = RRESP; data = RDATA;
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    initial begin
        logic        rdy, vld;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [15:0] pulse, pulse_after;

        ARSTn = 1'b0;
        AWVALID = 0; AWADDR = 0; AWPROT = 0; WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
        ARVALID = 0; ARADDR = 0; ARPROT = 0; RREADY = 0;

        //                wr  addr    data          strb  resp   val           pulse
        vecs[0]  = '{1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 16'h0002};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0};
        vecs[2]  = '{1'b1, 12'h008, 32'h12345678, 4'h3, 2'b00, 32'h00005678, 16'h0004};
        vecs[3]  = '{1'b0, 12'h00A, 32'h0,        4'h0, 2'b00, 32'h00005678, 16'h0};
        vecs[4]  = '{1'b1, 12'h008, 32'hAB000000, 4'h8, 2'b00, 32'hAB005678, 16'h0004};
        vecs[5]  = '{1'b0, 12'h008, 32'h0,        4'h0, 2'b00, 32'hAB005678, 16'h0};
        vecs[6]  = '{1'b1, 12'h03C, 32'hCAFEF00D, 4'hF, 2'b00, 32'hCAFEF00D, 16'h8000};
        vecs[7]  = '{1'b0, 12'h03F, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 16'h0};
        vecs[8]  = '{1'b1, 12'h040, 32'h00000055, 4'hF, 2'b10, 32'h0,        16'h0};
        vecs[9]  = '{1'b0, 12'h040, 32'h0,        4'h0, 2'b10, 32'h0,        16'h0};
        vecs[10] = '{1'b1, 12'hFFC, 32'h00000001, 4'hF, 2'b10, 32'h0,        16'h0};
        vecs[11] = '{1'b0, 12'hFFC, 32'h0,        4'h0, 2'b10, 32'h0,        16'h0};
        vecs[12] = '{1'b1, 12'h004, 32'hFFFFFFFF, 4'h0, 2'b00, 32'hDEADBEEF, 16'h0};
        vecs[13] = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0};
        vecs[14] = '{1'b0, 12'h000, 32'h0,        4'h0, 2'b00, 32'h0,        16'h0};

        // Reset state, then READYs stay low until the first edge after release.
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 0);
        chk("rst_regs_zero", {63'b0, |regs_o}, 0);
        chk("rst_pulse", {48'b0, wr_pulse_o}, 0);
        @(posedge ACLK); #2 ARSTn = 1'b1;
        @(negedge ACLK);
        chk("rst_ready_gated", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(negedge ACLK);
        chk("rst_ready_up", {AWREADY, WREADY, ARREADY}, 3'b111);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 3'b001,
                          rdy, vld, resp, pulse, pulse_after);
                chk($sformatf("v%0d_wready", i), rdy, 1);
                chk($sformatf("v%0d_bvalid", i), vld, 1);
                chk($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
                chk($sformatf("v%0d_pulse", i), pulse, vecs[i].pulse);
                chk($sformatf("v%0d_pulse_off", i), pulse_after, 0);
                if (vecs[i].resp == 2'b00)
                    chk($sformatf("v%0d_reg", i), reg_at(int'(vecs[i].addr >> 2)), vecs[i].val);
            end else begin
                axi_read(vecs[i].addr, 3'b001, rdy, vld, resp, data);
                chk($sformatf("v%0d_arready", i), rdy, 1);
                chk($sformatf("v%0d_rvalid", i), vld, 1);
                chk($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
                chk($sformatf("v%0d_rdata", i), data, vecs[i].val);
            end
        end

        // W three cycles ahead of AW; WREADY must stay low until B completes.
        @(posedge ACLK); #1;
        WVALID = 1'b1; WDATA = 32'h000000AA; WSTRB = 4'h1;
        @(negedge ACLK);
        chk("A_wready", WREADY, 1);
        @(posedge ACLK); #1 WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("A_wready_hold", {WREADY, BVALID}, 2'b00);
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWADDR = 12'h004; AWPROT = 3'b001;
        @(negedge ACLK);
        chk("A_awready", AWREADY, 1);
        @(posedge ACLK); #1 AWVALID = 1'b0;
        @(negedge ACLK);
        chk("A_b", {BVALID, BRESP, WREADY}, {1'b1, 2'b00, 1'b0});
        chk("A_pulse", wr_pulse_o, 16'h0002);
        chk("A_reg1", reg_at(1), 32'hDEADBEAA);
        BREADY = 1'b1;
        @(posedge ACLK); #1 BREADY = 1'b0;
        @(negedge ACLK);
        chk("A_drained", {BVALID, WREADY, AWREADY}, 3'b011);

        // Held responses under back-pressure, read and write concurrently.
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWADDR = 12'h010; AWPROT = 3'b001;
        WVALID = 1'b1; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 12'h040; ARPROT = 3'b001;
        @(negedge ACLK);
        chk("B_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("B_hold", {BVALID, BRESP, RVALID, RRESP, RDATA, AWREADY, WREADY, ARREADY},
                {1'b1, 2'b00, 1'b1, 2'b10, 32'h0, 3'b000});
        end
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0; RREADY = 1'b0;
        @(negedge ACLK);
        chk("B_drained", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);
        chk("B_reg4", reg_at(4), 32'h0BADF00D);

        // Same-edge commit and AR on reg3: read sees the old value.
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWADDR = 12'h00C; WVALID = 1'b1; WDATA = 32'h11111111; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 12'h00C;
        @(negedge ACLK);
        chk("C_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(negedge ACLK);
        chk("C_rdata_old", {RVALID, BVALID, RDATA}, {1'b1, 1'b1, 32'h0});
        chk("C_pulse", wr_pulse_o, 16'h0008);
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0; RREADY = 1'b0;
        axi_read(12'h00C, 3'b001, rdy, vld, resp, data);
        chk("C_rdata_new", {rdy, vld, resp, data}, {1'b1, 1'b1, 2'b00, 32'h11111111});

        // Reset while holding an AW: everything clears, transaction is abandoned.
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWADDR = 12'h010;
        @(negedge ACLK);
        chk("D_awready", AWREADY, 1);
        @(posedge ACLK); #1 AWVALID = 1'b0;
        @(negedge ACLK);
        chk("D_have_aw", {AWREADY, WREADY}, 2'b01);
        #1 ARSTn = 1'b0;
        #1;
        chk("D_rst_regs", {63'b0, |regs_o}, 0);
        chk("D_rst_outs", {BVALID, RVALID, AWREADY, WREADY, ARREADY, |wr_pulse_o}, 0);
        @(posedge ACLK); #2 ARSTn = 1'b1;
        @(negedge ACLK);
        chk("D_ready_gated", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(negedge ACLK);
        chk("D_idle", {AWREADY, WREADY, ARREADY, BVALID}, 4'b1110);
        axi_write(12'h010, 32'h00C0FFEE, 4'hF, 3'b000, rdy, vld, resp, pulse, pulse_after);
        chk("D_wr_handshake", {rdy, vld}, 2'b11);
`ifdef AXI4_LITE_PROT_CHECK_EN
        chk("D_prot_bresp", resp, 2'b10);
        chk("D_prot_pulse", pulse, 16'h0);
        chk("D_prot_reg4", reg_at(4), 32'h0);
`else
        chk("D_prot_bresp", resp, 2'b00);
        chk("D_prot_pulse", pulse, 16'h0010);
        chk("D_prot_reg4", reg_at(4), 32'h00C0FFEE);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
